// File: rtl/stream_fifo_rr_arbiter.sv
// stream_fifo_rr_arbiter: N_INP valid/ready input streams, each buffered in its
// own FIFO, merged onto one output stream by a round-robin arbiter with lock-in.
// Once a grant is shown with the sink stalled, that grant is held until it is
// accepted, so the output never changes under a pending transfer.
module stream_fifo_rr_arbiter #(
    parameter int N_INP        = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter int FALL_THROUGH = 0,
    localparam int IDX_W       = (N_INP > 1) ? $clog2(N_INP) : 1,
    localparam int FILL_W      = $clog2(DEPTH + 1),
    localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [N_INP-1:0]            in_valid_i,
    output logic [N_INP-1:0]            in_ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic [IDX_W-1:0]            out_idx_o,
    output logic [N_INP*FILL_W-1:0]     fill_o
);

    localparam bit FT = (FALL_THROUGH != 0);

    logic [N_INP-1:0]      cand;
    logic [N_INP-1:0]      push;
    logic [N_INP-1:0]      pop;
    logic [DATA_WIDTH-1:0] head [N_INP];

    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic                  handshake;

    logic [IDX_W-1:0]      rr_q, rr_d;
    logic                  lock_q, lock_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;

    int                    scan_int;
    logic [IDX_W-1:0]      scan_idx;

    assign handshake = grant_valid & out_ready_i;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_INP; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0]      rd_ptr_q;
            logic [PTR_W-1:0]      wr_ptr_q;
            logic [FILL_W-1:0]     cnt_q;
            logic                  empty;
            logic                  full;
            logic                  bypass;

            assign empty          = (cnt_q == '0);
            assign full           = (cnt_q == FILL_W'(DEPTH));
            assign in_ready_o[gi] = ~full;
            assign push[gi]       = in_valid_i[gi] & ~full;
            assign pop[gi]        = handshake & (grant_idx == IDX_W'(gi));
            // Push and pop on an empty fall-through FIFO: the word goes
            // straight to the output and is never written to storage.
            assign bypass         = FT & empty & push[gi] & pop[gi];
            assign cand[gi]       = ~empty | (FT & in_valid_i[gi]);
            assign head[gi]       = (FT && empty) ? in_data_i[gi*DATA_WIDTH +: DATA_WIDTH]
                                                  : mem_q[rd_ptr_q];
            assign fill_o[gi*FILL_W +: FILL_W] = cnt_q;

            // FIFO storage, pointers and occupancy; flush empties without touching storage.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    cnt_q    <= '0;
                    for (int e = 0; e < DEPTH; e++) begin
                        mem_q[e] <= '0;
                    end
                end else if (flush_i) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    cnt_q    <= '0;
                end else if (!bypass) begin
                    if (push[gi]) begin
                        mem_q[wr_ptr_q] <= in_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
                        wr_ptr_q        <= ptr_inc(wr_ptr_q);
                    end
                    if (pop[gi]) begin
                        rd_ptr_q <= ptr_inc(rd_ptr_q);
                    end
                    if (push[gi] && !pop[gi]) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!push[gi] && pop[gi]) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Grant selection: held index while locked, otherwise first candidate after rr_q.
    always_comb begin
        grant_valid = |cand;
        grant_idx   = '0;
        scan_int    = 0;
        scan_idx    = '0;
        if (lock_q) begin
            grant_idx = lock_idx_q;
        end else begin
            // Scan from farthest to nearest so the nearest candidate wins.
            for (int k = N_INP - 1; k >= 0; k--) begin
                scan_int = int'(rr_q) + 1 + k;
                if (scan_int >= N_INP) begin
                    scan_int = scan_int - N_INP;
                end
                scan_idx = IDX_W'(scan_int);
                if (cand[scan_idx]) begin
                    grant_idx = scan_idx;
                end
            end
        end
    end

    // Output stream: zeroed whenever nothing is valid.
    always_comb begin
        out_valid_o = grant_valid;
        out_idx_o   = grant_valid ? grant_idx : '0;
        out_data_o  = grant_valid ? head[grant_idx] : '0;
    end

    // Next round-robin pointer and lock state.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (handshake) begin
            rr_d   = grant_idx;
            lock_d = 1'b0;
        end else if (grant_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
        if (flush_i) begin
            rr_d   = rr_q;
            lock_d = 1'b0;
        end
    end

    // Arbiter state registers; after reset input 0 has first priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= IDX_W'(N_INP - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_stream_fifo_rr_arbiter.sv
// Testbench for stream_fifo_rr_arbiter: two instances (registered and
// fall-through) share stimulus; a queue-based reference model per instance
// predicts every output, and directed scenarios check the key sequences.
module tb_stream_fifo_rr_arbiter;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 flush_i;
    logic [N-1:0]         in_valid_i;
    logic [N*DW-1:0]      in_data_i;
    logic                 out_ready_i;

    logic [1:0]           ov;
    logic [1:0][N-1:0]    ir;
    logic [1:0][DW-1:0]   od;
    logic [1:0][IW-1:0]   oi;
    logic [1:0][N*FW-1:0] fl;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored words per instance and input, plus arbiter state.
    logic [DW-1:0] mq [2][N][$];
    int            m_rr [2];
    logic          m_lock [2];
    int            m_lock_idx [2];

    // Stimulus sources and log of accepted outputs of instance 0.
    logic [DW-1:0] src [N][$];
    logic [DW-1:0] log_d [$];
    int            log_i [$];

    always #5 clk_i = ~clk_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            stream_fifo_rr_arbiter #(
                .N_INP       (N),
                .DATA_WIDTH  (DW),
                .DEPTH       (DEPTH),
                .FALL_THROUGH(gi)
            ) dut (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (flush_i),
                .in_valid_i (in_valid_i),
                .in_ready_o (ir[gi]),
                .in_data_i  (in_data_i),
                .out_valid_o(ov[gi]),
                .out_ready_i(out_ready_i),
                .out_data_o (od[gi]),
                .out_idx_o  (oi[gi]),
                .fill_o     (fl[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d, input logic full_reset);
        for (int i = 0; i < N; i++) mq[d][i].delete();
        m_lock[d] = 1'b0;
        if (full_reset) begin
            m_rr[d]       = N - 1;
            m_lock_idx[d] = 0;
        end
    endtask

    // Compare instance d against the model for this cycle, then advance the model.
    task automatic check_and_update(input int d);
        logic [N-1:0]  cand;
        logic [N-1:0]  erdy;
        logic [DW-1:0] hd [N];
        logic [N*FW-1:0] efill;
        logic          ev;
        int            g;
        int            j;
        logic          hs;
        logic          bypass;
        efill = '0;
        for (int i = 0; i < N; i++) begin
            erdy[i] = (mq[d][i].size() < DEPTH);
            cand[i] = (mq[d][i].size() > 0) || (d == 1 && in_valid_i[i]);
            hd[i]   = (mq[d][i].size() > 0) ? mq[d][i][0] : in_data_i[i*DW +: DW];
            efill[i*FW +: FW] = FW'(mq[d][i].size());
        end
        ev = |cand;
        g  = 0;
        if (m_lock[d]) begin
            g = m_lock_idx[d];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = (m_rr[d] + 1 + k) % N;
                if (cand[j]) g = j;
            end
        end
        chk($sformatf("dut%0d out_valid", d), 64'(ov[d]), 64'(ev));
        chk($sformatf("dut%0d out_idx", d), 64'(oi[d]), ev ? 64'(g) : 64'd0);
        chk($sformatf("dut%0d out_data", d), 64'(od[d]), ev ? 64'(hd[g]) : 64'd0);
        chk($sformatf("dut%0d in_ready", d), 64'(ir[d]), 64'(erdy));
        chk($sformatf("dut%0d fill", d), 64'(fl[d]), 64'(efill));

        hs = ev && out_ready_i;
        if (rst_i) begin
            model_reset(d, 1'b1);
        end else if (flush_i) begin
            model_reset(d, 1'b0);
        end else begin
            if (d == 0 && hs) begin
                log_d.push_back(hd[g]);
                log_i.push_back(g);
            end
            for (int i = 0; i < N; i++) begin
                bypass = (d == 1) && (mq[d][i].size() == 0) && in_valid_i[i] && hs && (g == i);
                if (!bypass) begin
                    if (hs && g == i) void'(mq[d][i].pop_front());
                    if (in_valid_i[i] && erdy[i]) mq[d][i].push_back(in_data_i[i*DW +: DW]);
                end
            end
            if (hs) begin
                m_rr[d]   = g;
                m_lock[d] = 1'b0;
            end else if (ev) begin
                m_lock[d]     = 1'b1;
                m_lock_idx[d] = g;
            end
        end
    endtask

    // Monitor: checks both instances on every falling edge.
    initial begin
        model_reset(0, 1'b1);
        model_reset(1, 1'b1);
        forever begin
            @(negedge clk_i);
            check_and_update(0);
            check_and_update(1);
        end
    end

    // Present source heads for n cycles; pop those accepted by instance 0.
    task automatic drive_cycles(input int n);
        logic [N-1:0] acc;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid_i[i]         = (src[i].size() > 0);
                in_data_i[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : '0;
            end
            @(negedge clk_i);
            acc = in_valid_i & ir[0];
            @(posedge clk_i);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) void'(src[i].pop_front());
            end
        end
        in_valid_i = '0;
        in_data_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic check_log(input string nm, input logic [DW-1:0] exp_d [$], input int exp_i [$]);
        chk({nm, " count"}, 64'(log_d.size()), 64'(exp_d.size()));
        for (int k = 0; k < exp_d.size() && k < log_d.size(); k++) begin
            chk($sformatf("%s data[%0d]", nm, k), 64'(log_d[k]), 64'(exp_d[k]));
            chk($sformatf("%s idx[%0d]", nm, k), 64'(log_i[k]), 64'(exp_i[k]));
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        do_reset();

        // Reset state, then first push appears one cycle later.
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst dut%0d out_valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("rst dut%0d in_ready", d), 64'(ir[d]), 64'd3);
            chk($sformatf("rst dut%0d fill", d), 64'(fl[d]), 64'd0);
        end
        @(posedge clk_i); #1;
        src[0].push_back(32'hA5);
        drive_cycles(1);
        @(negedge clk_i);
        chk("first push out_valid", 64'(ov[0]), 64'd1);
        chk("first push out_data", 64'(od[0]), 64'hA5);
        chk("first push out_idx", 64'(oi[0]), 64'd0);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        drive_cycles(1);
        out_ready_i = 1'b0;

        // Fill to full on input 1, then drain.
        src[1] = '{32'h11, 32'h22, 32'h33};
        drive_cycles(4);
        @(negedge clk_i);
        chk("full in_ready1", 64'(ir[0][1]), 64'd0);
        chk("full fill1", 64'(fl[0][FW +: FW]), 64'(DEPTH));
        chk("full held off", 64'(src[1].size()), 64'd1);
        @(posedge clk_i); #1;
        log_d.delete(); log_i.delete();
        out_ready_i = 1'b1;
        drive_cycles(6);
        check_log("drain", '{32'h11, 32'h22, 32'h33}, '{1, 1, 1});
        out_ready_i = 1'b0;

        // Round-robin interleave from reset priority.
        do_reset();
        log_d.delete(); log_i.delete();
        src[0] = '{32'h01, 32'h02, 32'h03};
        src[1] = '{32'h11, 32'h12, 32'h13};
        out_ready_i = 1'b1;
        drive_cycles(9);
        check_log("rr", '{32'h01, 32'h11, 32'h02, 32'h12, 32'h03, 32'h13}, '{0, 1, 0, 1, 0, 1});
        out_ready_i = 1'b0;

        // Lock-in: grant on input 1 survives a higher-priority arrival.
        do_reset();
        src[1].push_back(32'h55);
        drive_cycles(1);
        src[0].push_back(32'h66);
        drive_cycles(2);
        @(negedge clk_i);
        chk("lock out_idx", 64'(oi[0]), 64'd1);
        chk("lock out_data", 64'(od[0]), 64'h55);
        @(posedge clk_i); #1;
        log_d.delete(); log_i.delete();
        out_ready_i = 1'b1;
        drive_cycles(3);
        check_log("lock", '{32'h55, 32'h66}, '{1, 0});
        out_ready_i = 1'b0;

        // Fall-through: same-cycle output, nothing stored.
        do_reset();
        out_ready_i = 1'b1;
        in_valid_i  = 2'b01;
        in_data_i[0 +: DW] = 32'h77;
        @(negedge clk_i);
        chk("ft out_valid", 64'(ov[1]), 64'd1);
        chk("ft out_data", 64'(od[1]), 64'h77);
        chk("ft out_idx", 64'(oi[1]), 64'd0);
        chk("noft out_valid", 64'(ov[0]), 64'd0);
        @(posedge clk_i); #1;
        in_valid_i = '0;
        in_data_i  = '0;
        @(negedge clk_i);
        chk("ft fill", 64'(fl[1]), 64'd0);
        chk("noft fill", 64'(fl[0]), 64'd1);
        @(posedge clk_i); #1;
        drive_cycles(2);
        out_ready_i = 1'b0;

        // Flush mid-operation discards contents and the concurrent push.
        src[0] = '{32'hA1, 32'hA2};
        drive_cycles(2);
        flush_i    = 1'b1;
        in_valid_i = 2'b01;
        in_data_i[0 +: DW] = 32'hEE;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = '0;
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("flush dut%0d fill", d), 64'(fl[d]), 64'd0);
            chk($sformatf("flush dut%0d out_valid", d), 64'(ov[d]), 64'd0);
        end
        @(posedge clk_i); #1;
        // Serve input 0 so that input 1 would lead without a reset.
        src[0].push_back(32'hB1);
        out_ready_i = 1'b1;
        drive_cycles(2);
        out_ready_i = 1'b0;
        src[0] = '{32'hC1, 32'hC2};
        drive_cycles(2);
        rst_i      = 1'b1;
        in_valid_i = 2'b01;
        in_data_i[0 +: DW] = 32'hEE;
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        in_valid_i = '0;
        @(negedge clk_i);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rstmid dut%0d fill", d), 64'(fl[d]), 64'd0);
            chk($sformatf("rstmid dut%0d out_valid", d), 64'(ov[d]), 64'd0);
        end
        @(posedge clk_i); #1;
        src[0].push_back(32'hD0);
        src[1].push_back(32'hD1);
        drive_cycles(1);
        @(negedge clk_i);
        chk("rstmid priority idx", 64'(oi[0]), 64'd0);
        chk("rstmid priority data", 64'(od[0]), 64'hD0);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        drive_cycles(3);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            rst_i       = ($urandom_range(0, 149) == 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                in_valid_i[i]         = ($urandom_range(0, 2) != 0);
                in_data_i[i*DW +: DW] = $urandom();
            end
            @(posedge clk_i); #1;
        end
        rst_i      = 1'b0;
        flush_i    = 1'b0;
        in_valid_i = '0;
        repeat (4) @(posedge clk_i);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo_rr_arbiter.md
Name: stream_fifo_rr_arbiter

Overview:
- Buffers N_INP independent valid/ready input streams, each in its own FIFO with fifo_v3 semantics.
- Merges the FIFO heads onto one output stream through a round-robin stream arbiter with lock-in.
- Used wherever several request sources, e.g. read and write request queues of a bus bridge, share one downstream port.

Parameters:
- N_INP, 2: number of input streams, >=1.
- DATA_WIDTH, 32: payload width in bits, >=1.
- DEPTH, 2: entries per input FIFO, >=1.
- FALL_THROUGH, 0: 1 = an empty FIFO presents pushed data combinationally in the same cycle.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of all FIFOs.
- in_valid_i  in  N_INP  per-input valid.
- in_ready_o  out  N_INP  per-input ready (= FIFO not full).
- in_data_i  in  N_INP*DATA_WIDTH  payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  output ready.
- out_data_o  out  DATA_WIDTH  granted payload.
- out_idx_o  out  max(1,$clog2(N_INP))  index of the granted input.
- fill_o  out  N_INP*$clog2(DEPTH+1)  per-FIFO occupancy.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All FIFOs become empty; pointers and storage clear to 0.
  - Round-robin pointer resets to N_INP-1, so input 0 has first priority.
  - Lock is cleared.
  - After reset: out_valid_o=0, in_ready_o all 1, fill_o=0, out_data_o=0, out_idx_o=0.
  - rst_i overrides flush_i and all handshakes. Reset during an active transfer discards all buffered data.
- FIFO i, per cycle:
  - push_i = in_valid_i[i] & in_ready_o[i]; in_ready_o[i] = ~full_i.
  - pop_i = output handshake with out_idx_o==i.
  - A push while full is not accepted (ready is low), even if a pop occurs the same cycle.
  - A pop while empty never occurs.
  - Simultaneous push and pop: occupancy unchanged, data order preserved.
  - Pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- Latency, FALL_THROUGH=0: data pushed in cycle t is poppable at earliest t+1.
- Latency, FALL_THROUGH=1:
  - When the FIFO is empty, the head equals in_data_i and the FIFO reads non-empty in the same cycle.
  - A simultaneous push and pop on an empty FIFO passes the data through without storing it; fill stays 0.
- Candidate: input i is a candidate when FIFO i is non-empty (or fall-through valid).
- Arbitration:
  - Search starts at (rr_ptr+1) mod N_INP and ascends with wrap-around. The first candidate is granted.
  - out_valid_o = any candidate. out_data_o / out_idx_o = head and index of the granted FIFO.
  - Both are 0 when out_valid_o=0.
- Lock-in: once out_valid_o is high with out_ready_i low, the grant is held until the handshake completes. A new higher-priority candidate does not change out_idx_o or out_data_o.
- Handshake (out_valid_o & out_ready_i):
  - Pops the granted FIFO.
  - Sets rr_ptr to the granted index.
  - Releases the lock.
  - rr_ptr changes only on a handshake.
- flush_i at an edge:
  - All FIFOs become empty and the lock is released; rr_ptr is unchanged.
  - Pushes and pops in that cycle are discarded.
- Throughput: one output transfer per cycle maximum. With out_ready_i held high and all inputs saturated, the grant order is 0,1,...,N_INP-1,0,...
- Width: fill_o per FIFO ranges 0..DEPTH. fill_o==DEPTH means full.

Test Plan:
- Reset: assert rst_i for 2 cycles, then release -> out_valid_o=0, in_ready_o=2'b11, fill_o=0. Push 0xA5 on input 0 (FALL_THROUGH=0) -> out_valid_o=1 next cycle, out_data_o=0xA5, out_idx_o=0.
- Fill/full: DEPTH=2, out_ready_i=0, push 0x11, 0x22, 0x33 on input 1 -> after 2 pushes in_ready_o[1]=0 and 0x33 is held off. Raise out_ready_i -> outputs 0x11 then 0x22; 0x33 is accepted once space frees.
- Round-robin: both inputs hold 3 entries (input 0: 0x01..0x03, input 1: 0x11..0x13), out_ready_i=1 -> output sequence 0x01,0x11,0x02,0x12,0x03,0x13 with out_idx_o alternating 0,1.
- Lock-in: input 1 valid with 0x55 while out_ready_i=0; then input 0 becomes valid (higher priority after reset) -> out_idx_o stays 1 with 0x55 until the handshake; input 0 is served next.
- Fall-through: FALL_THROUGH=1, empty FIFO, push 0x77 with out_ready_i=1 -> out_valid_o=1 and out_data_o=0x77 in the same cycle; fill_o stays 0.
- Flush / reset mid-operation: FIFO 0 holds 2 entries, pulse flush_i -> next cycle fill_o=0, out_valid_o=0, and the push offered in the flush cycle is lost. Repeat using rst_i -> same result, and priority returns to input 0.
